multicycle_cu: RTL and testbench

MULTICYCLE_CU -- requirements
Module: multicycle_cu

---
 rtl/multicycle_cu.sv | 236 +++++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cu.sv
// Multicycle control unit for a small ARM-like datapath: fetch/decode/exec/mem/wb
// sequencing, memory-wait timeout, retired-instruction count and sticky error code.
//
// state  | meaning
// FETCH  | write IR, PC <= PC+4
// DECODE | classify and latch opcode
// EXEC   | ALU operation; branches resolve PC here
// MEM    | data memory access, wait for mem_ready with timeout
// WB     | register file write-back
// HALT   | illegal opcode or memory timeout; held until reset
module multicycle_cu #(
  parameter int OPC_W   = 11,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16,
  parameter int MEM_TMO = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               ir_wr,
  output logic               pc_wr,
  output logic               pc_src,
  output logic               reg2loc,
  output logic               alu_src,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               mem_to_reg,
  output logic               reg_wr,
  output logic [1:0]         seu,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   retired,
  output logic [1:0]         err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_ILL, C_ADD, C_SUB, C_AND, C_ORR, C_LDUR, C_STUR, C_LSL, C_LSR,
    C_B, C_CBZ, C_CBNZ, C_ADDI, C_SUBI, C_ANDI, C_ORRI
  } cls_e;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TMO - 1);

  state_e            state_q, state_d;
  logic [10:0]       opc_q, opc_d;
  logic [7:0]        wait_q, wait_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  ret_q, ret_d;

  logic [10:0]       opc_top;
  cls_e              cls_in, cls_lat;
  logic [2:0]        f_alu_op;
  logic [1:0]        f_seu;
  logic              f_alu_src, f_reg2loc;
  logic              is_b, is_cbz, is_cbnz, is_br, is_ld, is_st;
  logic              retire;

  // Match classes are disjoint, so evaluation order carries no priority.
  function automatic cls_e classify(input logic [10:0] op);
    cls_e c;
    c = C_ILL;
    if      (op == 11'b10001011000) c = C_ADD;
    else if (op == 11'b11001011000) c = C_SUB;
    else if (op == 11'b10001010000) c = C_AND;
    else if (op == 11'b10101010000) c = C_ORR;
    else if (op == 11'b11111000010) c = C_LDUR;
    else if (op == 11'b11111000000) c = C_STUR;
    else if (op == 11'b11010011011) c = C_LSL;
    else if (op == 11'b11010011010) c = C_LSR;
    else if (op[10:5] == 6'b000101)     c = C_B;
    else if (op[10:3] == 8'b10110100)   c = C_CBZ;
    else if (op[10:3] == 8'b10110101)   c = C_CBNZ;
    else if (op[10:1] == 10'b1001000100) c = C_ADDI;
    else if (op[10:1] == 10'b1101000100) c = C_SUBI;
    else if (op[10:1] == 10'b1001001000) c = C_ANDI;
    else if (op[10:1] == 10'b1011001000) c = C_ORRI;
    return c;
  endfunction

  assign opc_top = opcode[OPC_W-1 -: 11];
  assign cls_in  = classify(opc_top);
  assign cls_lat = classify(opc_q);

  always_comb begin
    f_alu_op  = 3'd0;
    f_seu     = 2'd0;
    f_alu_src = 1'b0;
    f_reg2loc = 1'b0;
    unique case (cls_lat)
      C_ADD:  f_alu_op = 3'd0;
      C_SUB:  f_alu_op = 3'd1;
      C_AND:  f_alu_op = 3'd2;
      C_ORR:  f_alu_op = 3'd3;
      C_LDUR: begin f_alu_op = 3'd0; f_seu = 2'd1; f_alu_src = 1'b1; end
      C_STUR: begin f_alu_op = 3'd0; f_seu = 2'd1; f_alu_src = 1'b1; f_reg2loc = 1'b1; end
      C_LSL:  begin f_alu_op = 3'd5; f_alu_src = 1'b1; end
      C_LSR:  begin f_alu_op = 3'd6; f_alu_src = 1'b1; end
      C_B:    begin f_alu_op = 3'd0; f_seu = 2'd2; end
      C_CBZ,
      C_CBNZ: begin f_alu_op = 3'd4; f_seu = 2'd3; f_reg2loc = 1'b1; end
      C_ADDI: begin f_alu_op = 3'd0; f_alu_src = 1'b1; end
      C_SUBI: begin f_alu_op = 3'd1; f_alu_src = 1'b1; end
      C_ANDI: begin f_alu_op = 3'd2; f_alu_src = 1'b1; end
      C_ORRI: begin f_alu_op = 3'd3; f_alu_src = 1'b1; end
      default: ;
    endcase
  end

  assign is_b    = (cls_lat == C_B);
  assign is_cbz  = (cls_lat == C_CBZ);
  assign is_cbnz = (cls_lat == C_CBNZ);
  assign is_br   = is_b | is_cbz | is_cbnz;
  assign is_ld   = (cls_lat == C_LDUR);
  assign is_st   = (cls_lat == C_STUR);

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    wait_d  = wait_q;
    err_d   = err_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        opc_d = opc_top;
        if (cls_in == C_ILL) begin
          state_d = S_HALT;
          err_d   = 2'd1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_br) begin
          state_d = S_FETCH;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
          wait_d  = 8'd0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // A ready strobe on the last allowed cycle still completes normally.
        if (mem_ready) begin
          state_d = is_ld ? S_WB : S_FETCH;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == TMO_LAST) begin
            state_d = S_HALT;
            err_d   = 2'd2;
          end
        end
      end
      S_WB:   state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        err_d   = 2'd1;
      end
    endcase
  end

  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));
  assign ret_d  = ret_q + CNT_W'(retire);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      opc_q   <= 11'd0;
      wait_q  <= 8'd0;
      err_q   <= 2'd0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    seu        = 2'd0;
    alu_op     = '0;
    unique case (state_q)
      S_FETCH: begin
        ir_wr = 1'b1;
        pc_wr = 1'b1;
      end
      S_EXEC, S_MEM, S_WB: begin
        seu     = f_seu;
        alu_op  = ALUOP_W'(f_alu_op);
        alu_src = f_alu_src;
        reg2loc = f_reg2loc;
        if (state_q == S_EXEC && is_br) begin
          pc_wr  = 1'b1;
          pc_src = is_b | (is_cbz & zero) | (is_cbnz & ~zero);
        end
        if (state_q == S_MEM) begin
          mem_rd = is_ld;
          mem_wr = is_st;
        end
        if (state_q == S_WB) begin
          reg_wr     = 1'b1;
          mem_to_reg = is_ld;
        end
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign retired = ret_q;
  assign err     = err_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: instruction-level reference model built from the opcode
// table, per-cycle output comparison, directed scenarios plus a random instruction stream.
module tb_multicycle_cu;
  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, zero, mem_ready;
  logic [10:0] opcode;

  logic ir_wr, pc_wr, pc_src, reg2loc, alu_src, mem_rd, mem_wr, mem_to_reg, reg_wr;
  logic [1:0] seu, err;
  logic [2:0] alu_op, state;
  logic [15:0] retired;

  logic d4_ir_wr, d4_pc_wr, d4_pc_src, d4_reg2loc, d4_alu_src, d4_mem_rd, d4_mem_wr;
  logic d4_mem_to_reg, d4_reg_wr;
  logic [1:0] d4_seu, d4_err;
  logic [2:0] d4_alu_op, d4_state;
  logic [3:0] d4_retired;

  multicycle_cu dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .reg2loc(reg2loc), .alu_src(alu_src),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_to_reg(mem_to_reg), .reg_wr(reg_wr),
    .seu(seu), .alu_op(alu_op), .state(state), .retired(retired), .err(err)
  );

  multicycle_cu #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ir_wr(d4_ir_wr), .pc_wr(d4_pc_wr), .pc_src(d4_pc_src), .reg2loc(d4_reg2loc),
    .alu_src(d4_alu_src), .mem_rd(d4_mem_rd), .mem_wr(d4_mem_wr),
    .mem_to_reg(d4_mem_to_reg), .reg_wr(d4_reg_wr), .seu(d4_seu), .alu_op(d4_alu_op),
    .state(d4_state), .retired(d4_retired), .err(d4_err)
  );

  typedef struct packed {
    logic [2:0]  state;
    logic [1:0]  err;
    logic [15:0] ret;
    logic [3:0]  ret4;
    logic ir_wr, pc_wr, pc_src, reg2loc, alu_src, mem_rd, mem_wr, mem_to_reg, reg_wr;
    logic [1:0]  seu;
    logic [2:0]  alu_op;
  } obs_t;

  // Instruction table: pattern, significant top bits, alu_op, seu, alu_src, reg2loc, kind
  // kind: 0 ALU/write-back, 1 load, 2 store, 3 B, 4 CBZ, 5 CBNZ
  logic [10:0] T_PAT [15] = '{11'b10001011000, 11'b11001011000, 11'b10001010000,
                              11'b10101010000, 11'b11111000010, 11'b11111000000,
                              11'b11010011011, 11'b11010011010, 11'b00010100000,
                              11'b10110100000, 11'b10110101000, 11'b10010001000,
                              11'b11010001000, 11'b10010010000, 11'b10110010000};
  int T_LEN  [15] = '{11, 11, 11, 11, 11, 11, 11, 11, 6, 8, 8, 10, 10, 10, 10};
  int T_ALU  [15] = '{0, 1, 2, 3, 0, 0, 5, 6, 0, 4, 4, 0, 1, 2, 3};
  int T_SEU  [15] = '{0, 0, 0, 0, 1, 1, 0, 0, 2, 3, 3, 0, 0, 0, 0};
  int T_SRC  [15] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
  int T_R2L  [15] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
  int T_KIND [15] = '{0, 0, 0, 0, 1, 2, 0, 0, 3, 4, 5, 0, 0, 0, 0};
  logic [10:0] ILL [5] = '{11'b00000000000, 11'b11111111111, 11'b10001011001,
                           11'b10110110000, 11'b00010000000};

  int   tests = 0, failed = 0, ncyc = 0;
  int   m_ret = 0;
  logic [1:0] m_err = 2'd0;
  bit   halted = 0;
  bit   chk_en = 0;
  obs_t exp_cur, act;
  string tag = "";

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      act.state = state;       act.err = err;         act.ret = retired;
      act.ret4 = d4_retired;   act.ir_wr = ir_wr;     act.pc_wr = pc_wr;
      act.pc_src = pc_src;     act.reg2loc = reg2loc; act.alu_src = alu_src;
      act.mem_rd = mem_rd;     act.mem_wr = mem_wr;   act.mem_to_reg = mem_to_reg;
      act.reg_wr = reg_wr;     act.seu = seu;         act.alu_op = alu_op;
      tests++;
      if (act !== exp_cur) begin
        failed++;
        $display("FAIL %s cyc=%0d got=%h want=%h", tag, ncyc, act, exp_cur);
      end
    end
  end

  task automatic lit(input string name, input int a, input int x);
    tests++;
    if (a !== x) begin
      failed++;
      $display("FAIL %s got=%0d want=%0d", name, a, x);
    end
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t e;
    e = '0;
    e.state = st;
    e.err   = m_err;
    e.ret   = 16'(m_ret);
    e.ret4  = 4'(m_ret);
    return e;
  endfunction

  function automatic obs_t fetch_exp();
    obs_t e;
    e = base(3'd0);
    e.ir_wr = 1'b1;
    e.pc_wr = 1'b1;
    return e;
  endfunction

  function automatic obs_t with_fields(input obs_t e_in, input int idx);
    obs_t e;
    e = e_in;
    e.alu_op  = 3'(T_ALU[idx]);
    e.seu     = 2'(T_SEU[idx]);
    e.alu_src = 1'(T_SRC[idx]);
    e.reg2loc = 1'(T_R2L[idx]);
    return e;
  endfunction

  task automatic cyc(input obs_t e, input logic [10:0] opc, input logic z,
                     input logic mr, input logic rb, input string t);
    @(negedge clk);
    opcode = opc; zero = z; mem_ready = mr; rst_n = rb;
    exp_cur = e; tag = t; chk_en = 1;
    @(posedge clk);
    ncyc++;
  endtask

  task automatic model_reset();
    m_ret = 0; m_err = 2'd0; halted = 0;
  endtask

  task automatic do_reset(input obs_t e);
    cyc(e, 11'($urandom), rbit(), rbit(), 1'b0, "reset");
    model_reset();
  endtask

  task automatic halt_then_reset(input int n);
    for (int i = 0; i < n; i++) cyc(base(3'd5), 11'($urandom), rbit(), rbit(), 1'b1, "halt");
    do_reset(base(3'd5));
  endtask

  task automatic run_illegal(input logic [10:0] opc);
    cyc(fetch_exp(), 11'($urandom), rbit(), rbit(), 1'b1, "fetch");
    cyc(base(3'd1), opc, rbit(), rbit(), 1'b1, "decode_ill");
    m_err = 2'd1; halted = 1;
  endtask

  // One instruction; w = ready-low MEM cycles, rst_at = MEM cycle index to reset on (-1 none)
  task automatic run_instr(input int idx, input logic z, input int w, input int rst_at);
    obs_t e;
    logic [10:0] opc, mask;
    logic mr;
    int k;
    k = T_KIND[idx];
    mask = (11'd1 << (11 - T_LEN[idx])) - 11'd1;
    opc = T_PAT[idx] | (11'($urandom) & mask);
    cyc(fetch_exp(), 11'($urandom), rbit(), rbit(), 1'b1, "fetch");
    cyc(base(3'd1), opc, rbit(), rbit(), 1'b1, "decode");
    e = with_fields(base(3'd2), idx);
    if (k >= 3) begin
      e.pc_wr  = 1'b1;
      e.pc_src = (k == 3) ? 1'b1 : (k == 4) ? z : ~z;
    end
    cyc(e, 11'($urandom), z, rbit(), 1'b1, "exec");
    if (k >= 3) begin
      m_ret++;
      return;
    end
    if (k == 1 || k == 2) begin
      for (int i = 0; i < TMO; i++) begin
        mr = (i == w);
        e = with_fields(base(3'd3), idx);
        e.mem_rd = (k == 1);
        e.mem_wr = (k == 2);
        if (i == rst_at) begin
          cyc(e, 11'($urandom), rbit(), mr, 1'b0, "mem_rst");
          model_reset();
          return;
        end
        cyc(e, 11'($urandom), rbit(), mr, 1'b1, "mem");
        if (mr) break;
        if (i == TMO - 1) begin
          m_err = 2'd2; halted = 1;
          return;
        end
      end
      if (k == 2) begin
        m_ret++;
        return;
      end
    end
    e = with_fields(base(3'd4), idx);
    e.reg_wr     = 1'b1;
    e.mem_to_reg = (k == 1);
    cyc(e, 11'($urandom), rbit(), rbit(), 1'b1, "wb");
    m_ret++;
  endtask

  initial begin
    int n0, idx, w, ra;
    rst_n = 1'b0; opcode = 11'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset(fetch_exp());
    #1;
    lit("reset_state", int'(state), 0);
    lit("reset_retired", int'(retired), 0);
    lit("reset_err", int'(err), 0);

    run_instr(0, 1'b0, 0, -1);
    #1;
    lit("add_retired", int'(retired), 1);
    lit("add_back_to_fetch", int'(state), 0);

    do_reset(fetch_exp());
    run_instr(10, 1'b0, 0, -1);
    run_instr(9, 1'b0, 0, -1);
    #1;
    lit("cb_retired", int'(retired), 2);

    do_reset(fetch_exp());
    n0 = ncyc;
    run_instr(4, 1'b0, 3, -1);
    #1;
    lit("ldur_cycles", ncyc - n0, 8);
    lit("ldur_retired", int'(retired), 1);

    run_instr(5, 1'b0, TMO + 5, -1);
    #1;
    lit("tmo_state", int'(state), 5);
    lit("tmo_err", int'(err), 2);
    lit("tmo_retired", int'(retired), 1);
    halt_then_reset(5);
    #1;
    lit("post_halt_state", int'(state), 0);

    run_instr(8, 1'b0, 0, -1);
    run_illegal(11'b00000000000);
    #1;
    lit("ill_state", int'(state), 5);
    lit("ill_err", int'(err), 1);
    lit("ill_retired", int'(retired), 1);
    halt_then_reset(3);

    run_instr(5, 1'b0, TMO - 1, -1);
    #1;
    lit("late_ready_err", int'(err), 0);
    lit("late_ready_state", int'(state), 0);

    run_instr(4, 1'b1, 5, 2);
    #1;
    lit("mem_reset_state", int'(state), 0);
    lit("mem_reset_retired", int'(retired), 0);

    for (int i = 0; i < 15; i++) run_instr(8, rbit(), 0, -1);
    #1;
    lit("wrap4_before", int'(d4_retired), 15);
    run_instr(8, rbit(), 0, -1);
    #1;
    lit("wrap4_after", int'(d4_retired), 0);
    lit("wrap16_count", int'(retired), 16);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        run_illegal(ILL[$urandom_range(0, 4)]);
      end else begin
        idx = $urandom_range(0, 14);
        w  = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
        ra = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 2) : -1;
        run_instr(idx, rbit(), w, ra);
      end
      if (halted) halt_then_reset($urandom_range(1, 3));
    end

    @(negedge clk);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
